// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared matmul types and default sizes for the result scratchpad
package matmul_pkg;

  localparam int MM_DATA_WIDTH  = 4;
  localparam int MM_BUS_WIDTH   = 16;
  localparam int MM_SP_NTARGETS = 4;
  localparam int MM_MAX_DIM     = MM_BUS_WIDTH / MM_DATA_WIDTH;

  typedef logic signed [MM_BUS_WIDTH-1:0]           data_bus_t;
  typedef data_bus_t [MM_MAX_DIM-1:0]               sp_row_t;
  typedef logic [$clog2(MM_SP_NTARGETS)-1:0]        sp_target_t;
  typedef logic [$clog2(MM_MAX_DIM)-1:0]            sp_idx_t;

  typedef enum logic [0:0] {
    SP_IDLE,
    SP_CLEAR
  } sp_state_e;

endpackage

// File: rtl/matmul_sp_acc_lane.sv
// rtl/matmul_sp_acc_lane.sv - one scratchpad lane: overwrite or signed accumulate with overflow detect
// MATMUL_SP_SAT_EN selects saturating accumulate; otherwise results wrap.
module matmul_sp_acc_lane #(
  parameter int BUS_WIDTH = 16
) (
  input  logic [BUS_WIDTH-1:0] i_old,
  input  logic [BUS_WIDTH-1:0] i_new,
  input  logic                 i_accum,
  output logic [BUS_WIDTH-1:0] o_result,
  output logic                 o_ovf
);

  logic signed [BUS_WIDTH:0] w_sum;

  // One extra bit of headroom: overflow shows up as the top two bits disagreeing.
  assign w_sum = $signed({i_old[BUS_WIDTH-1], i_old}) + $signed({i_new[BUS_WIDTH-1], i_new});
  assign o_ovf = i_accum && (w_sum[BUS_WIDTH] != w_sum[BUS_WIDTH-1]);

  always_comb begin
    o_result = i_new;
    if (i_accum) begin
`ifdef MATMUL_SP_SAT_EN
      if (o_ovf) begin
        o_result = w_sum[BUS_WIDTH] ? {1'b1, {(BUS_WIDTH-1){1'b0}}} : {1'b0, {(BUS_WIDTH-1){1'b1}}};
      end else begin
        o_result = w_sum[BUS_WIDTH-1:0];
      end
`else
      o_result = w_sum[BUS_WIDTH-1:0];
`endif
    end
  end

endmodule

// File: rtl/matmul_sp_bank.sv
// rtl/matmul_sp_bank.sv - matmul result scratchpad: row writes/accumulate, element reads, slot clear
module matmul_sp_bank
  import matmul_pkg::*;
#(
  parameter int  DATA_WIDTH  = MM_DATA_WIDTH,
  parameter int  BUS_WIDTH   = MM_BUS_WIDTH,
  parameter int  SP_NTARGETS = MM_SP_NTARGETS,
  localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
  localparam int TW          = $clog2(SP_NTARGETS),
  localparam int IW          = $clog2(MAX_DIM)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         wr_valid_i,
  output logic                         wr_ready_o,
  input  logic [TW-1:0]                wr_target_i,
  input  logic [IW-1:0]                wr_row_i,
  input  logic                         wr_accum_i,
  input  logic [MAX_DIM*BUS_WIDTH-1:0] wr_data_i,
  input  logic                         rd_req_i,
  input  logic [TW-1:0]                rd_target_i,
  input  logic [IW-1:0]                rd_row_i,
  input  logic [IW-1:0]                rd_col_i,
  output logic                         rd_valid_o,
  output logic [BUS_WIDTH-1:0]         rd_data_o,
  input  logic                         clr_i,
  input  logic [TW-1:0]                clr_target_i,
  output logic                         busy_o,
  output logic [SP_NTARGETS-1:0]       ovf_o
);

  logic [MAX_DIM*BUS_WIDTH-1:0] r_mem [SP_NTARGETS][MAX_DIM];
  sp_state_e                    r_state;
  logic [IW-1:0]                r_clr_row;
  logic [TW-1:0]                r_clr_target;
  logic                         r_busy;
  logic [SP_NTARGETS-1:0]       r_ovf;
  logic                         r_rd_valid;
  logic [BUS_WIDTH-1:0]         r_rd_data;

  logic                         w_wr_in_range;
  logic                         w_rd_in_range;
  logic                         w_wr_fire;
  logic [MAX_DIM*BUS_WIDTH-1:0] w_old_row;
  logic [MAX_DIM*BUS_WIDTH-1:0] w_new_row;
  logic [MAX_DIM-1:0]           w_lane_ovf;

  // A clear request wins over a same-cycle write; the writer simply stalls.
  assign wr_ready_o    = (r_state == SP_IDLE) && !clr_i;
  assign w_wr_in_range = (int'(wr_target_i) < SP_NTARGETS) && (int'(wr_row_i) < MAX_DIM);
  assign w_rd_in_range = (int'(rd_target_i) < SP_NTARGETS) && (int'(rd_row_i) < MAX_DIM)
                         && (int'(rd_col_i) < MAX_DIM);
  assign w_wr_fire     = wr_valid_i && wr_ready_o && w_wr_in_range;
  assign w_old_row     = r_mem[wr_target_i][wr_row_i];

  for (genvar g = 0; g < MAX_DIM; g++) begin : g_lane
    matmul_sp_acc_lane #(
      .BUS_WIDTH(BUS_WIDTH)
    ) u_lane (
      .i_old   (w_old_row[g*BUS_WIDTH +: BUS_WIDTH]),
      .i_new   (wr_data_i[g*BUS_WIDTH +: BUS_WIDTH]),
      .i_accum (wr_accum_i),
      .o_result(w_new_row[g*BUS_WIDTH +: BUS_WIDTH]),
      .o_ovf   (w_lane_ovf[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= SP_IDLE;
      r_clr_row    <= '0;
      r_clr_target <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        SP_IDLE: begin
          if (clr_i) begin
            r_state      <= SP_CLEAR;
            r_clr_target <= clr_target_i;
            r_clr_row    <= '0;
            r_busy       <= 1'b1;
          end
        end
        SP_CLEAR: begin
          if (r_clr_row == IW'(MAX_DIM-1)) begin
            r_state <= SP_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_clr_row <= r_clr_row + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int t = 0; t < SP_NTARGETS; t++) begin
        for (int r = 0; r < MAX_DIM; r++) begin
          r_mem[t][r] <= '0;
        end
      end
      r_ovf      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      if (r_state == SP_CLEAR) begin
        r_mem[r_clr_target][r_clr_row] <= '0;
        if (r_clr_row == '0) begin
          r_ovf[r_clr_target] <= 1'b0;
        end
      end else if (w_wr_fire) begin
        r_mem[wr_target_i][wr_row_i] <= w_new_row;
        if (|w_lane_ovf) begin
          r_ovf[wr_target_i] <= 1'b1;
        end
      end
      // Reads sample pre-edge storage, so a colliding write/clear returns the old element.
      r_rd_valid <= rd_req_i;
      if (rd_req_i) begin
        r_rd_data <= w_rd_in_range ? r_mem[rd_target_i][rd_row_i][rd_col_i*BUS_WIDTH +: BUS_WIDTH]
                                   : '0;
      end
    end
  end

  assign busy_o     = r_busy;
  assign ovf_o      = r_ovf;
  assign rd_valid_o = r_rd_valid;
  assign rd_data_o  = r_rd_data;

endmodule

// File: tb/tb_matmul_sp_bank.sv
// tb/tb_matmul_sp_bank.sv - scoreboard bench for matmul_sp_bank with directed vectors
module tb_matmul_sp_bank;
  import matmul_pkg::*;

  localparam int BW = MM_BUS_WIDTH;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       wr_valid_i = 1'b0;
  logic       wr_ready_o;
  sp_target_t wr_target_i = '0;
  sp_idx_t    wr_row_i = '0;
  logic       wr_accum_i = 1'b0;
  sp_row_t    wr_data_i = '0;
  logic       rd_req_i = 1'b0;
  sp_target_t rd_target_i = '0;
  sp_idx_t    rd_row_i = '0;
  sp_idx_t    rd_col_i = '0;
  logic       rd_valid_o;
  logic [BW-1:0] rd_data_o;
  logic       clr_i = 1'b0;
  sp_target_t clr_target_i = '0;
  logic       busy_o;
  logic [MM_SP_NTARGETS-1:0] ovf_o;

  matmul_sp_bank u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .wr_target_i (wr_target_i),
    .wr_row_i    (wr_row_i),
    .wr_accum_i  (wr_accum_i),
    .wr_data_i   (wr_data_i),
    .rd_req_i    (rd_req_i),
    .rd_target_i (rd_target_i),
    .rd_row_i    (rd_row_i),
    .rd_col_i    (rd_col_i),
    .rd_valid_o  (rd_valid_o),
    .rd_data_o   (rd_data_o),
    .clr_i       (clr_i),
    .clr_target_i(clr_target_i),
    .busy_o      (busy_o),
    .ovf_o       (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [BW-1:0] data;
    int            cyc;
    string         name;
  } rd_exp_t;

  rd_exp_t q[$];
  rd_exp_t mon_e;
  int checks = 0;
  int errors = 0;

`ifdef MATMUL_SP_SAT_EN
  localparam logic [BW-1:0] ACC_OVF_EXP = 16'h7FFF;
`else
  localparam logic [BW-1:0] ACC_OVF_EXP = 16'h8010;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input sp_target_t t, input sp_idx_t r, input logic acc, input sp_row_t d);
    int n;
    n = 0;
    wr_valid_i  = 1'b1;
    wr_target_i = t;
    wr_row_i    = r;
    wr_accum_i  = acc;
    wr_data_i   = d;
    #1;
    while (!wr_ready_o && n < 20) begin
      step();
      n++;
    end
    chk("wr_ready_at_accept", 32'(wr_ready_o), 32'd1);
    step();
    wr_valid_i = 1'b0;
  endtask

  task automatic rd(input sp_target_t t, input sp_idx_t r, input sp_idx_t c,
                    input logic [BW-1:0] exp, input string name);
    rd_req_i    = 1'b1;
    rd_target_i = t;
    rd_row_i    = r;
    rd_col_i    = c;
    q.push_back('{exp, cyc + 1, name});
    step();
    rd_req_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (rd_valid_o) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got rd_valid_o=1 data 0x%0h expected no read", rd_data_o);
      end else begin
        mon_e = q.pop_front();
        checks++;
        if (rd_data_o !== mon_e.data || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL %s: got 0x%0h at cycle %0d expected 0x%0h at cycle %0d",
                   mon_e.name, rd_data_o, cyc, mon_e.data, mon_e.cyc);
        end
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: got no rd_valid_o at cycle %0d expected data 0x%0h",
               mon_e.name, cyc, mon_e.data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000 expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    step();
    step();
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_ovf", 32'(ovf_o), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("reset_rd_data", 32'(rd_data_o), 32'd0);
    rst_ni = 1'b1;
    step();
    chk("idle_wr_ready", 32'(wr_ready_o), 32'd1);

    wr(2'd2, 2'd1, 1'b0, 64'h0004_0003_0002_0001);
    rd(2'd2, 2'd1, 2'd0, 16'd1, "slot2_r1_c0");
    rd(2'd2, 2'd1, 2'd1, 16'd2, "slot2_r1_c1");
    rd(2'd2, 2'd1, 2'd2, 16'd3, "slot2_r1_c2");
    rd(2'd2, 2'd1, 2'd3, 16'd4, "slot2_r1_c3");

    wr(2'd0, 2'd0, 1'b0, 64'h0000_0000_0000_7FF0);
    wr(2'd0, 2'd0, 1'b1, 64'h0000_0000_0000_0020);
    chk("acc_ovf_flag", 32'(ovf_o), 32'h1);
    rd(2'd0, 2'd0, 2'd0, ACC_OVF_EXP, "acc_ovf_result");
    rd(2'd0, 2'd0, 2'd1, 16'h0000, "acc_ovf_other_lane");

    wr(2'd3, 2'd2, 1'b1, 64'h0000_FFFB_0000_0000);
    rd(2'd3, 2'd2, 2'd2, 16'hFFFB, "acc_minus5");
    wr(2'd3, 2'd2, 1'b1, 64'h0000_0003_0000_0000);
    rd(2'd3, 2'd2, 2'd2, 16'hFFFE, "acc_minus2");
    chk("acc_no_ovf", 32'(ovf_o), 32'h1);

    clr_i        = 1'b1;
    clr_target_i = 2'd0;
    wr_valid_i   = 1'b1;
    wr_target_i  = 2'd0;
    wr_row_i     = 2'd3;
    wr_accum_i   = 1'b0;
    wr_data_i    = 64'h0000_0000_0000_1234;
    #1;
    chk("clr_beats_wr", 32'(wr_ready_o), 32'd0);
    step();
    clr_i = 1'b0;
    n = 0;
    while (busy_o && n < 20) begin
      n++;
      chk("ready_low_in_clear", 32'(wr_ready_o), 32'd0);
      if (n == 2) chk("ovf_cleared_first_cycle", 32'(ovf_o), 32'd0);
      step();
    end
    chk("clear_busy_cycles", 32'(n), 32'd4);
    chk("ready_after_clear", 32'(wr_ready_o), 32'd1);
    step();
    wr_valid_i = 1'b0;
    rd(2'd0, 2'd0, 2'd0, 16'h0000, "cleared_r0_c0");
    rd(2'd0, 2'd3, 2'd0, 16'h1234, "stalled_write_landed");
    rd(2'd0, 2'd3, 2'd1, 16'h0000, "stalled_write_lane1");
    chk("ovf_after_clear", 32'(ovf_o), 32'd0);

    wr(2'd1, 2'd0, 1'b0, 64'h0000_0000_0000_0007);
    wr_valid_i  = 1'b1;
    wr_target_i = 2'd1;
    wr_row_i    = 2'd0;
    wr_accum_i  = 1'b0;
    wr_data_i   = 64'h0000_0000_0000_0009;
    rd(2'd1, 2'd0, 2'd0, 16'h0007, "read_old_on_collision");
    wr_valid_i = 1'b0;
    rd(2'd1, 2'd0, 2'd0, 16'h0009, "read_new_after_collision");

    wr(2'd1, 2'd0, 1'b1, 64'h0000_0000_0000_7FFF);
    chk("slot1_ovf", 32'(ovf_o), 32'h2);
    clr_i        = 1'b1;
    clr_target_i = 2'd2;
    step();
    clr_i = 1'b0;
    chk("busy_clear_cycle1", 32'(busy_o), 32'd1);
    step();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    chk("busy_after_mid_reset", 32'(busy_o), 32'd0);
    chk("ovf_after_mid_reset", 32'(ovf_o), 32'd0);
    rd(2'd2, 2'd1, 2'd3, 16'h0000, "mid_reset_slot2");
    rd(2'd1, 2'd0, 2'd0, 16'h0000, "mid_reset_slot1");
    rd(2'd3, 2'd2, 2'd2, 16'h0000, "mid_reset_slot3");
    rd(2'd0, 2'd3, 2'd0, 16'h0000, "mid_reset_slot0");

    step();
    step();
    step();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
